// File: rtl/f_accumulator.sv
// Registered 4-bit ALU stage: one of 16 arithmetic/logic/shift ops is computed each cycle
// and captured into Y together with a carry/borrow/shifted-out status bit.
module f_accumulator (
   input  logic       Clk,
   input  logic       nReset,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] mode,
   input  logic       cin,
   output logic [3:0] Y,
   output logic       carryb
);

   typedef enum logic [3:0] {
      OpAdd  = 4'h0,
      OpSub  = 4'h1,
      OpCmp  = 4'h2,
      OpAnd  = 4'h3,
      OpOr   = 4'h4,
      OpNot  = 4'h5,
      OpInc  = 4'h6,
      OpDec  = 4'h7,
      OpShl0 = 4'h8,
      OpShl1 = 4'h9,
      OpShr0 = 4'hA,
      OpShr1 = 4'hB,
      OpSla  = 4'hC,
      OpSra  = 4'hD,
      OpRol  = 4'hE,
      OpRor  = 4'hF
   } op_e;

   op_e op;
   assign op = op_e'(mode);

   // Five-bit arithmetic: bit 4 is carry for sums and borrow for differences.
   logic [4:0] add_sum;
   logic [4:0] sub_diff;
   logic [4:0] inc_sum;
   logic [4:0] dec_diff;

   always_comb begin
      add_sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      sub_diff = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      inc_sum  = {1'b0, a} + 5'd1;
      dec_diff = {1'b0, a} - 5'd1;
   end

   logic [3:0] cmp_res;

   always_comb begin
      cmp_res = 4'b0000;
      if (a > b) begin
         cmp_res = 4'b0001;
      end else if (a == b) begin
         cmp_res = 4'b0010;
      end else begin
         cmp_res = 4'b0100;
      end
   end

   logic [3:0] y_d;
   logic       c_d;

   always_comb begin
      y_d = 4'h0;
      c_d = 1'b0;
      unique case (op)
         OpAdd: begin
            y_d = add_sum[3:0];
            c_d = add_sum[4];
         end
         OpSub: begin
            y_d = sub_diff[3:0];
            c_d = sub_diff[4];
         end
         OpCmp:  y_d = cmp_res;
         OpAnd:  y_d = a & b;
         OpOr:   y_d = a | b;
         OpNot:  y_d = ~a;
         OpInc: begin
            y_d = inc_sum[3:0];
            c_d = inc_sum[4];
         end
         OpDec: begin
            y_d = dec_diff[3:0];
            c_d = dec_diff[4];
         end
         OpShl0, OpSla: begin
            y_d = {a[2:0], 1'b0};
            c_d = a[3];
         end
         OpShl1: begin
            y_d = {a[2:0], 1'b1};
            c_d = a[3];
         end
         OpShr0: begin
            y_d = {1'b0, a[3:1]};
            c_d = a[0];
         end
         OpShr1: begin
            y_d = {1'b1, a[3:1]};
            c_d = a[0];
         end
         OpSra: begin
            y_d = {a[3], a[3:1]};
            c_d = a[0];
         end
         OpRol: begin
            y_d = {a[2:0], a[3]};
            c_d = a[3];
         end
         OpRor: begin
            y_d = {a[0], a[3:1]};
            c_d = a[0];
         end
         default: begin
            y_d = 4'h0;
            c_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Y      <= 4'h0;
         carryb <= 1'b0;
      end else begin
         Y      <= y_d;
         carryb <= c_d;
      end
   end

endmodule

// File: tb/tb_f_accumulator.sv
// Bench for f_accumulator: directed vectors with hand-derived results, then random vectors
// against an arithmetic reference model; outputs are also checked to hold before each edge.
module tb_f_accumulator;

   logic       Clk;
   logic       nReset;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] mode;
   logic       cin;
   logic [3:0] Y;
   logic       carryb;

   int total = 0;
   int bad   = 0;
   logic [4:0] prev_exp;

   f_accumulator dut (
      .Clk    (Clk),
      .nReset (nReset),
      .a      (a),
      .b      (b),
      .mode   (mode),
      .cin    (cin),
      .Y      (Y),
      .carryb (carryb)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got c=%b y=%h, expected c=%b y=%h", tag, got[4], got[3:0], exp[4],
                  exp[3:0]);
      end
   endtask

   // Reference model built from the operation rules with integer arithmetic; returns {c, r}.
   function automatic logic [4:0] ref_alu(input int m, input int x, input int y, input int ci);
      int r;
      int c;
      r = 0;
      c = 0;
      case (m)
         0: begin r = (x + y + ci) % 16; c = (x + y + ci > 15) ? 1 : 0; end
         1: begin r = (x - y - ci + 32) % 16; c = (x < y + ci) ? 1 : 0; end
         2: r = (x > y) ? 1 : ((x == y) ? 2 : 4);
         3: r = x & y;
         4: r = x | y;
         5: r = 15 - x;
         6: begin r = (x + 1) % 16; c = (x == 15) ? 1 : 0; end
         7: begin r = (x + 15) % 16; c = (x == 0) ? 1 : 0; end
         8, 12: begin r = (x * 2) % 16; c = x / 8; end
         9: begin r = (x * 2) % 16 + 1; c = x / 8; end
         10: begin r = x / 2; c = x % 2; end
         11: begin r = x / 2 + 8; c = x % 2; end
         13: begin r = x / 2 + ((x >= 8) ? 8 : 0); c = x % 2; end
         14: begin r = (x * 2) % 16 + x / 8; c = x / 8; end
         default: begin r = x / 2 + (x % 2) * 8; c = x % 2; end
      endcase
      return 5'(c * 16 + r);
   endfunction

   task automatic run_vec(input string tag, input int m, input int x, input int y, input int ci,
                          input logic [4:0] exp);
      @(negedge Clk);
      mode = 4'(m);
      a    = 4'(x);
      b    = 4'(y);
      cin  = 1'(ci);
      #1;
      check({tag, "_hold"}, {carryb, Y}, prev_exp);
      @(posedge Clk);
      #1;
      check(tag, {carryb, Y}, exp);
      prev_exp = exp;
   endtask

   initial begin
      nReset   = 1'b0;
      a        = 4'h0;
      b        = 4'h0;
      mode     = 4'h0;
      cin      = 1'b0;
      prev_exp = 5'h00;

      repeat (2) @(posedge Clk);
      #1;
      check("reset", {carryb, Y}, 5'h00);
      @(negedge Clk);
      nReset = 1'b1;

      // ADD
      run_vec("add_2_1",  0, 2, 1, 0, {1'b0, 4'd3});
      run_vec("add_5_5",  0, 5, 5, 0, {1'b0, 4'd10});
      run_vec("add_9_9",  0, 9, 9, 0, {1'b1, 4'd2});
      run_vec("add_3_9",  0, 3, 9, 0, {1'b0, 4'd12});
      run_vec("add_cin",  0, 15, 0, 1, {1'b1, 4'd0});

      // Asynchronous reset between edges with a SUB pending
      @(negedge Clk);
      mode   = 4'h1;
      a      = 4'd3;
      b      = 4'd1;
      nReset = 1'b0;
      #1;
      check("rst_async", {carryb, Y}, 5'h00);
      repeat (2) begin
         @(posedge Clk);
         #1;
         check("rst_hold", {carryb, Y}, 5'h00);
      end
      #2;
      nReset   = 1'b1;
      prev_exp = 5'h00;
      run_vec("sub_7_2",  1, 7, 2, 0, {1'b0, 4'd5});
      run_vec("sub_2_5",  1, 2, 5, 0, {1'b1, 4'd13});
      run_vec("sub_cin",  1, 0, 15, 1, {1'b1, 4'd0});

      // CMP / logic
      run_vec("cmp_gt",   2, 2, 1, 0, {1'b0, 4'b0001});
      run_vec("cmp_lt",   2, 1, 4, 1, {1'b0, 4'b0100});
      run_vec("cmp_eq",   2, 6, 6, 0, {1'b0, 4'b0010});
      run_vec("and",      3, 7, 8, 0, {1'b0, 4'd0});
      run_vec("or",       4, 3, 6, 0, {1'b0, 4'd7});
      run_vec("not",      5, 7, 0, 0, {1'b0, 4'd8});

      // INC / DEC wrap
      run_vec("inc_7",    6, 7, 0, 0, {1'b0, 4'd8});
      run_vec("inc_15",   6, 15, 0, 0, {1'b1, 4'd0});
      run_vec("dec_13",   7, 13, 0, 0, {1'b0, 4'd12});
      run_vec("dec_0",    7, 0, 0, 0, {1'b1, 4'd15});

      // Shifts and rotates
      run_vec("shl0",     8, 4'b1001, 0, 0, {1'b1, 4'b0010});
      run_vec("shl1",     9, 4'b0001, 0, 0, {1'b0, 4'b0011});
      run_vec("shr0",    10, 4'b1011, 0, 0, {1'b1, 4'b0101});
      run_vec("shr1",    11, 4'b1000, 0, 0, {1'b0, 4'b1100});
      run_vec("sra",     13, 4'b1011, 0, 0, {1'b1, 4'b1101});
      run_vec("sla",     12, 4'b1010, 0, 0, {1'b1, 4'b0100});
      run_vec("rol_9",   14, 4'b1001, 0, 0, {1'b1, 4'b0011});
      run_vec("rol_5",   14, 4'b0101, 0, 0, {1'b0, 4'b1010});
      run_vec("ror_a",   15, 4'b1010, 0, 0, {1'b0, 4'b0101});
      run_vec("ror_e",   15, 4'b1110, 0, 0, {1'b0, 4'b0111});

      // Random sweep against the reference model
      for (int i = 0; i < 400; i++) begin
         int m;
         int x;
         int y;
         int ci;
         m  = int'($urandom_range(15, 0));
         x  = int'($urandom_range(15, 0));
         y  = int'($urandom_range(15, 0));
         ci = int'($urandom_range(1, 0));
         run_vec($sformatf("rand_m%0d", m), m, x, y, ci, ref_alu(m, x, y, ci));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
